// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: performs LB/LH/LW/LBU/LHU/SB/SH/SW as single-byte
// transactions on a byte-wide memory port and returns an extended result.
module mem_access_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   base_q;
  logic [2:0]          func3_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          idx_q;
  logic [1:0]          last_q;
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                accept;
  logic                req_legal;
  logic [1:0]          req_last;
  logic [DATA_W-1:0]   asm_merged;
  logic [DATA_W-1:0]   load_ext;

  assign accept = req_valid && (state == IDLE);

  // Request decode: legality and index of the final byte for this size
  always_comb begin
    req_legal = 1'b0;
    req_last  = 2'd3;
    case (req_func3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !req_write;
      default:                req_legal = 1'b0;
    endcase
    case (req_func3[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

  // Word including the byte arriving this cycle, then sign/zero extension
  always_comb begin
    asm_merged = asm_q;
    asm_merged[{idx_q, 3'b000} +: 8] = mem_rdata;
    case (func3_q)
      3'b000:  load_ext = {{(DATA_W-8){asm_merged[7]}}, asm_merged[7:0]};
      3'b001:  load_ext = {{(DATA_W-16){asm_merged[15]}}, asm_merged[15:0]};
      3'b100:  load_ext = {{(DATA_W-8){1'b0}}, asm_merged[7:0]};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}}, asm_merged[15:0]};
      default: load_ext = asm_merged;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = req_legal ? ACCESS : RESP;
      end
      ACCESS: begin
        mem_addr = base_q + ADDR_W'(idx_q);
        mem_re   = !write_q;
        mem_we   = write_q;
        if (write_q) mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
        if (idx_q == last_q) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, byte assembly and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      func3_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        base_q  <= req_addr;
        func3_q <= req_func3;
        write_q <= req_write;
        wdata_q <= req_wdata;
        idx_q   <= '0;
        last_q  <= req_last;
        asm_q   <= '0;
        rdata_q <= '0;
        err_q   <= !req_legal;
      end else if (state == ACCESS) begin
        idx_q <= idx_q + 2'd1;
        if (!write_q) asm_q <= asm_merged;
        if (idx_q == last_q) rdata_q <= write_q ? '0 : load_ext;
      end else if (state == RESP && resp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Initiator-side load/store sequencer for the unified byte-addressable data memory.
- Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time from the pipeline MEM stage over a valid/ready handshake.
- Performs the access as a series of single-byte transactions on a byte-wide memory port, then returns an assembled, sign- or zero-extended result with a response handshake.
- Drives the stall source for the MEM stage while busy.

Parameters:
ADDR_W, 11, byte-address width; address arithmetic wraps modulo 2^ADDR_W.
DATA_W, 32, request/response data width; fixed at 32 (4 byte lanes).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_write  input  1  1 = store, 0 = load
req_func3  input  3  RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  input  ADDR_W  byte base address
req_wdata  input  32  store data (low bytes used)
resp_valid  output  1  response available
resp_ready  input  1  consumer takes response
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  illegal func3 for the request type
busy  output  1  high whenever state != IDLE (MEM stall)
mem_addr  output  ADDR_W  byte address to memory
mem_re  output  1  byte read strobe
mem_we  output  1  byte write strobe (memory writes on clk rise)
mem_wdata  output  8  byte to write
mem_rdata  input  8  combinational read byte at mem_addr

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1; busy=0; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_re=0; mem_we=0; mem_addr=0; mem_wdata=0.
  - Internal byte index, byte count and assembly register cleared.
  - Reset mid-ACCESS aborts immediately: mem_we drops asynchronously, no further bytes are written, and no response is produced.
- req_ready = (state==IDLE). A request is accepted on a rising edge with req_valid && req_ready. On acceptance, addr, func3, write flag and wdata are latched. Later changes on req_* inputs have no effect.
- Byte count N from func3[1:0]: 00→1, 01→2, 10→4.
- Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Any other code is illegal.
- Illegal request:
  - IDLE→RESP directly, with no memory strobes.
  - resp_err=1, resp_rdata=0.
- Legal request: IDLE→ACCESS with idx=0.
- ACCESS, one byte per cycle:
  - mem_addr = (base + idx) mod 2^ADDR_W. Wrap from 2^ADDR_W−1 to 0 is legal and required.
  - Load: mem_re=1, mem_we=0. The byte on mem_rdata is captured into lane idx (bits 8·idx+7 : 8·idx) at the rising edge.
  - Store: mem_we=1, mem_re=0, mem_wdata = wdata lane idx.
  - idx increments each edge. After the edge with idx==N−1 → RESP.
- Exactly one of mem_re/mem_we is high in ACCESS; both are low in IDLE and RESP.
- RESP:
  - resp_valid=1, held until resp_ready is sampled high, then → IDLE.
  - resp_rdata is registered and stable while resp_valid is high.
- Load result extension (little-endian):
  - LB: sign-extend bit 7. LH: sign-extend bit 15.
  - LBU/LHU: zero-extend. LW: all four lanes.
  - Store: resp_rdata=0.
- Latency: with resp_ready tied high, acceptance at edge k gives:
  - bytes on cycles k..k+N−1, resp_valid during cycle k+N;
  - next acceptance at edge k+N+2 (earliest).
- No misalignment restriction; any address is sequenced bytewise.
- resp_ready while not in RESP is ignored. req_valid while busy is ignored (no queuing).

Test Plan:
- Reset, then SW addr=0x010, wdata=0xDEADBEEF:
  - mem_we high 4 cycles at 0x010..0x013 with bytes EF, BE, AD, DE;
  - resp_valid with rdata=0, err=0.
- LB addr=0x020 with memory byte 0x80 → resp_rdata=0xFFFFFF80. LBU at the same address → 0x00000080.
- LH addr=0x7FF (wrap), mem[0x7FF]=0x34, mem[0x000]=0x92:
  - mem_addr sequence 0x7FF, 0x000;
  - resp_rdata=0xFFFF9234. LHU → 0x00009234.
- Store with func3=100:
  - no mem_we/mem_re pulses;
  - next cycle resp_valid=1, resp_err=1, resp_rdata=0.
- Backpressure: LW with resp_ready=0 for 5 cycles:
  - resp_valid and resp_rdata held stable;
  - req_ready=0 and busy=1 throughout; a second req_valid is not accepted until after the resp handshake.
- Assert rst_n=0 during the 2nd byte of an SW to 0x040:
  - mem_we falls immediately, only mem[0x040] is written, no resp_valid;
  - after release req_ready=1.
